// File: rtl/tx_fifo_module.sv
// Byte FIFO and transmit sequencer feeding a UART transmitter (IDLE -> SEND -> GAP).
// Define TX_FIFO_OVF_EN to add the sticky overflow flag (ovf_flag) and its clear input (ovf_clr).
module tx_fifo_module #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef TX_FIFO_OVF_EN
    input  logic                     ovf_clr,
    output logic                     ovf_flag,
`endif
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     tx_en_sig,
    output logic [7:0]               tx_data,
    input  logic                     tx_done_sig,
    output logic                     busy
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    logic [7:0]        mem [DEPTH];
    state_e            state_q,  state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              tx_en_q,  tx_en_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              wr_accept;
    logic              pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign tx_en_sig = tx_en_q;
    assign tx_data   = tx_data_q;
    assign busy      = (state_q != IDLE);

    // A write while full is dropped even if a pop happens in the same cycle.
    assign wr_accept = wr_en && !full;
    assign pop       = (state_q == IDLE) && !empty;

    always_comb begin
        state_d   = state_q;
        tx_en_d   = tx_en_q;
        tx_data_d = tx_data_q;
        wr_ptr_d  = wr_accept ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

        unique case ({wr_accept, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d   = SEND;
                    tx_en_d   = 1'b1;
                    tx_data_d = mem[rd_ptr_q];
                end
            end
            SEND: begin
                if (tx_done_sig) begin
                    state_d = GAP;
                    tx_en_d = 1'b0;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
        end
    end

    // NOTE: storage is deliberately not reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

`ifdef TX_FIFO_OVF_EN
    logic ovf_q, ovf_d;

    // Set wins over clear when both land in the same cycle.
    always_comb begin
        ovf_d = (ovf_q && !ovf_clr) || (wr_en && full);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_flag = ovf_q;
`endif

endmodule

// File: tb/tb_tx_fifo_module.sv
// Directed bench for tx_fifo_module: reset, latency, frame sequencing, full/drop, wrap and mid-frame reset.
module tb_tx_fifo_module;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       tx_en_sig;
    logic [7:0] tx_data;
    logic       tx_done_sig;
    logic       busy;
`ifdef TX_FIFO_OVF_EN
    logic       ovf_clr;
    logic       ovf_flag;
`endif

    int checks    = 0;
    int errors    = 0;
    int max_count = 0;
    logic [7:0] exp_q[$];

    tx_fifo_module dut (
        .clk         (clk),
        .rst         (rst),
`ifdef TX_FIFO_OVF_EN
        .ovf_clr     (ovf_clr),
        .ovf_flag    (ovf_flag),
`endif
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .tx_en_sig   (tx_en_sig),
        .tx_data     (tx_data),
        .tx_done_sig (tx_done_sig),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle; tracks the peak stored count.
    task automatic step();
        @(posedge clk);
        #1;
        if (int'(count) > max_count) max_count = int'(count);
    endtask

    task automatic wait_tx_en(input string tag);
        int n = 0;
        while (tx_en_sig !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check({tag, "_en"}, tx_en_sig, 1);
    endtask

    // Done pulse, GAP, IDLE: afterwards the next frame (if any) is in SEND.
    task automatic finish_frame();
        tx_done_sig = 1'b1;
        step();
        tx_done_sig = 1'b0;
        step();
        step();
    endtask

    initial begin
        rst         = 1'b1;
        wr_en       = 1'b0;
        wr_data     = 8'h00;
        tx_done_sig = 1'b0;
`ifdef TX_FIFO_OVF_EN
        ovf_clr     = 1'b0;
`endif
        step();
        step();
        check("rst_tx_en", tx_en_sig, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        rst = 1'b0;

        // Single byte: stored on the first edge, launched on the second.
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        check("lat_count1", count, 1);
        check("lat_en_early", tx_en_sig, 0);
        step();
        check("lat_en", tx_en_sig, 1);
        check("lat_data", tx_data, 8'hA5);
        check("lat_count0", count, 0);
        check("lat_busy", busy, 1);

        repeat (100) step();
        check("hold_en", tx_en_sig, 1);
        check("hold_data", tx_data, 8'hA5);
        tx_done_sig = 1'b1;
        step();
        tx_done_sig = 1'b0;
        check("gap_en", tx_en_sig, 0);
        check("gap_busy", busy, 1);
        step();
        check("idle_en", tx_en_sig, 0);
        check("idle_busy", busy, 0);

        // Burst of 16 bytes; byte 0 launches during the burst.
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            step();
        end
        wr_en = 1'b0;
        check("burst_count", count, 15);
        for (int k = 0; k < 16; k++) begin
            check("seq_en", tx_en_sig, 1);
            check("seq_data", tx_data, 32'(k));
            repeat (50) step();
            tx_done_sig = 1'b1;
            step();
            tx_done_sig = 1'b0;
            check("seq_gap_en", tx_en_sig, 0);
            check("seq_gap_busy", busy, 1);
            step();
            check("seq_idle_en", tx_en_sig, 0);
            check("seq_idle_busy", busy, 0);
            step();
        end
        check("seq_end_en", tx_en_sig, 0);
        check("seq_end_empty", empty, 1);
        check("seq_end_count", count, 0);

        // Fill behind an in-flight frame, then overflow with 8'hFF.
        wr_en   = 1'b1;
        wr_data = 8'h10;
        step();
        wr_en = 1'b0;
        step();
        check("full_inflight", tx_data, 8'h10);
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'h20 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        check("full_flag", full, 1);
        check("full_count", count, 16);
        wr_en   = 1'b1;
        wr_data = 8'hFF;
        step();
        wr_en = 1'b0;
        check("ovf_count", count, 16);
        check("ovf_full", full, 1);
`ifdef TX_FIFO_OVF_EN
        check("ovf_set", ovf_flag, 1);
        step();
        check("ovf_sticky", ovf_flag, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_clr", ovf_flag, 0);
`endif
        for (int k = 0; k < 17; k++) begin
            logic [7:0] exp_b;
            exp_b = (k == 0) ? 8'h10 : 8'h20 + 8'(k - 1);
            wait_tx_en("drain");
            check("drain_data", tx_data, exp_b);
            finish_frame();
        end
        repeat (5) step();
        check("drain_no_ff", tx_en_sig, 0);
        check("drain_empty", empty, 1);
        check("drain_busy", busy, 0);

        // Wrap: 40 bytes through in four rounds of ten.
        max_count = 0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 10; i++) begin
                wr_en   = 1'b1;
                wr_data = 8'h40 + 8'(r * 10 + i);
                exp_q.push_back(wr_data);
                step();
            end
            wr_en = 1'b0;
            for (int j = 0; j < 10; j++) begin
                logic [7:0] exp_b;
                exp_b = exp_q.pop_front();
                wait_tx_en("wrap");
                check("wrap_data", tx_data, exp_b);
                finish_frame();
            end
        end
        check("wrap_max_le16", 32'(max_count <= 16), 1);
        check("wrap_empty", empty, 1);

        // Reset in SEND with five bytes queued.
        for (int i = 0; i < 6; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'h80 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        check("mid_busy", busy, 1);
        check("mid_count", count, 5);
        check("mid_data", tx_data, 8'h80);
        rst = 1'b1;
        step();
        check("mid_rst_en", tx_en_sig, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_data", tx_data, 8'h00);
        check("mid_rst_busy", busy, 0);
        rst = 1'b0;
        repeat (3) step();
        check("post_rst_en", tx_en_sig, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
